// File: rtl/datapath.sv
// Datapath: instruction pointer, IR, GPR file, read latch and SRAM bus steering.
// Buses use bit 0 as MSB throughout.
module datapath #(
    parameter logic [0:1] DBUS_MEM = 2'b00,
    parameter logic [0:1] DBUS_GPR = 2'b01,
    parameter logic [0:1] ABUS_IP  = 2'b00,
    parameter logic [0:1] ABUS_CU  = 2'b01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reset_internal,
    input  logic [0:1]  data_select,
    input  logic [0:1]  address_select,
    input  logic        sram_en,
    input  logic        write_en,
    input  logic        ir_load,
    input  logic        gpr_load,
    input  logic        ip_increment,
    input  logic [0:3]  ra,
    input  logic [0:7]  cu_address,
    input  logic [0:15] mem_rdata,
    output logic [0:15] ir_data,
    output logic [0:7]  mem_addr,
    output logic [0:15] mem_wdata,
    output logic        mem_ce_n,
    output logic        mem_we_n,
    output logic [0:7]  ip
);

    logic [0:7]  ip_q;
    logic        inc_prev;
    logic [0:15] rd_latch;
    logic [0:15] ir_q;
    logic [0:15] gpr [0:15];
    logic [0:15] dbus;

    // IP advances once per rising edge of ip_increment; internal clear wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ip_q     <= '0;
            inc_prev <= 1'b0;
        end else if (!reset_internal) begin
            ip_q     <= '0;
            inc_prev <= 1'b0;
        end else begin
            if (ip_increment && !inc_prev)
                ip_q <= ip_q + 8'd1;
            inc_prev <= ip_increment;
        end
    end

    // Read latch captures SRAM data on every enabled read cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rd_latch <= '0;
        else if (!sram_en && write_en)
            rd_latch <= mem_rdata;
    end

    // Data bus source mux; unknown codes drive zero.
    always_comb begin
        dbus = '0;
        if (data_select == DBUS_MEM)
            dbus = rd_latch;
        else if (data_select == DBUS_GPR)
            dbus = gpr[ra];
    end

    // Address bus source mux; unknown codes drive zero.
    always_comb begin
        mem_addr = '0;
        if (address_select == ABUS_IP)
            mem_addr = ip_q;
        else if (address_select == ABUS_CU)
            mem_addr = cu_address;
    end

    // Instruction register loads from the data bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ir_q <= '0;
        else if (ir_load)
            ir_q <= dbus;
    end

    // General purpose register file, written from the data bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++)
                gpr[i] <= '0;
        end else if (gpr_load) begin
            gpr[ra] <= dbus;
        end
    end

    // Forward the incoming word so the control unit decodes it on the load edge.
    always_comb begin
        ir_data = ir_load ? dbus : ir_q;
    end

    // SRAM strobes are held inactive during either reset.
    always_comb begin
        mem_ce_n = reset | ~reset_internal | sram_en;
        mem_we_n = mem_ce_n | write_en;
    end

    assign mem_wdata = gpr[ra];
    assign ip        = ip_q;

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 The parameters SHALL be: DBUS_MEM, default 2'b00, data-bus source is the read latch; DBUS_GPR, default 2'b01, data-bus source is GPR[ra]; ABUS_IP, default 2'b00, address source is IP; ABUS_CU, default 2'b01, address source is cu_address.
REQ-002 The clock and reset SHALL be: reset is asynchronous and active-high; the clock is clk.
REQ-003 Ports SHALL be as follows; bit 0 is the MSB of every bus:
 clk  in  1  clock
 reset  in  1  async active-high reset
 reset_internal  in  1  active-low synchronous clear from control unit
 data_select  in  [0:1]  data-bus source select
 address_select  in  [0:1]  address-bus source select
 sram_en  in  1  memory enable, 0 = enabled
 write_en  in  1  0 = write, 1 = read
 ir_load  in  1  load IR from data bus
 gpr_load  in  1  load GPR[ra] from data bus
 ip_increment  in  1  IP advance request
 ra  in  [0:3]  GPR index
 cu_address  in  [0:7]  operand address from control unit
 mem_rdata  in  [0:15]  SRAM read data
 ir_data  out  [0:15]  instruction word to control unit
 mem_addr  out  [0:7]  SRAM address
 mem_wdata  out  [0:15]  SRAM write data
 mem_ce_n  out  1  SRAM chip enable, active-low
 mem_we_n  out  1  SRAM write enable, active-low
 ip  out  [0:7]  current instruction pointer

Function
REQ-004 IP SHALL be an 8-bit register, incremented by 1 modulo 256 (0xFF -> 0x00).
REQ-005 IP SHALL increment only on a clock where ip_increment=1 and the registered previous ip_increment=0; a held-high ip_increment SHALL produce exactly one increment.
REQ-006 When reset_internal=0 on a clock edge, IP and the previous-ip_increment register SHALL clear to 0; this clear SHALL win over a simultaneous increment.
REQ-007 The read latch (16 bits) SHALL capture mem_rdata on every clock where sram_en=0 and write_en=1; otherwise it SHALL hold its value.
REQ-008 The data bus SHALL be: the read latch for DBUS_MEM; GPR[ra] for DBUS_GPR; 0x0000 for any other code.
REQ-009 mem_addr SHALL be combinational: IP for ABUS_IP; cu_address for ABUS_CU; 0x00 for any other code.
REQ-010 mem_wdata SHALL equal GPR[ra] combinationally, regardless of data_select.
REQ-011 The GPR file SHALL hold 16 x 16-bit registers; on a clock with gpr_load=1, GPR[ra] SHALL take the data-bus value.
REQ-012 IR SHALL be 16 bits and SHALL load from the data bus on a clock with ir_load=1.
REQ-013 ir_data SHALL follow these rules:
 - while ir_load=1: the data-bus value, forwarded combinationally, so the control unit decodes the new word on the same edge IR captures it;
 - otherwise: the IR register.
REQ-014 If ir_load and gpr_load are both 1, both targets SHALL load the same data-bus value.
REQ-015 If gpr_load=1 with DBUS_GPR selected, GPR[ra] SHALL reload its own pre-edge value.
REQ-016 mem_ce_n SHALL be 1 while reset=1 or reset_internal=0; otherwise it SHALL equal sram_en.
REQ-017 mem_we_n SHALL be 0 only when mem_ce_n=0 and write_en=0; otherwise it SHALL be 1.
REQ-018 Latency SHALL be as follows:
 - memory read data is visible on the data bus one cycle after the enabled read cycle;
 - a GPR or IR write is visible on the cycle after the load edge.

Reset
REQ-019 Asserting reset SHALL immediately clear IP, the previous-ip_increment register, IR, the read latch and all 16 GPRs to 0.
REQ-020 Asserting reset SHALL immediately force mem_ce_n=1 and mem_we_n=1.
REQ-021 Reset asserted mid-access SHALL abort the access with no GPR, IR or IP update on that edge.
REQ-022 After reset deasserts, registers SHALL hold their values until the first qualifying clock.

Verification
REQ-023 Fetch: IP=0x00, mem_rdata=0x1234 (opcode 1, ra 2, addr 0x34), ABUS_IP, sram_en=0, write_en=1 for 1 cycle, then ir_load=1 with DBUS_MEM -> ir_data=0x1234 during the ir_load cycle, and IR=0x1234 after it.
REQ-024 Load: cu_address=0x34, ABUS_CU, mem_rdata=0xBEEF read for 1 cycle, then gpr_load=1 with ra=2 -> mem_addr=0x34 during the read, and GPR[2]=0xBEEF afterwards.
REQ-025 Store: GPR[2]=0xBEEF, DBUS_GPR, ABUS_CU, cu_address=0x40, sram_en=0, write_en=0 -> mem_addr=0x40, mem_wdata=0xBEEF, mem_ce_n=0, mem_we_n=0, and the read latch unchanged.
REQ-026 IP edge and wrap:
 - IP=0xFF, ip_increment held 1 for 3 cycles -> IP=0x00 after the first edge, then stays 0x00;
 - ip_increment low 1 cycle then high again -> IP=0x01.
REQ-027 Clear priority: reset_internal=0 with a simultaneous ip_increment rising edge -> IP=0x00 and mem_ce_n=1 despite sram_en=0.
REQ-028 Async reset mid-operation: reset pulsed between clock edges during a gpr_load cycle -> all GPRs and IR read 0x0000 and IP reads 0x00 with no clock edge, and no write on the next edge.
